// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the arbiter-PUF response collector.
// State encoding, LFSR feedback taps and default block dimensions.
package puf_ctrl_pkg;

   localparam int DEF_CHAL_W        = 45;
   localparam int DEF_RESP_BITS     = 32;
   localparam int DEF_SETTLE_CYCLES = 8;

   // Fibonacci taps 45,44,42,41 (1-based stage numbers) as a bit mask
   localparam logic [DEF_CHAL_W-1:0] LFSR_TAPS =
      (45'd1 << 44) | (45'd1 << 43) | (45'd1 << 41) | (45'd1 << 40);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      SETTLE,
      CAPTURE,
      RECOVER,
      DONE
   } state_t;

endpackage

// File: rtl/puf_lfsr.sv
// Challenge generator: loadable Fibonacci LFSR, new bit enters q[0].
// A zero seed is replaced by 1 so the register never locks up.
module puf_lfsr
   import puf_ctrl_pkg::*;
#(
   parameter int CHAL_W = DEF_CHAL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [CHAL_W-1:0] seed,
   input  logic              step,
   output logic [CHAL_W-1:0] q
);

   localparam logic [CHAL_W-1:0] TAPS = CHAL_W'(LFSR_TAPS);

   logic fb;
   assign fb = ^(q & TAPS);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (load)
         q <= (seed == '0) ? CHAL_W'(1) : seed;
      else if (step)
         q <= {q[CHAL_W-2:0], fb};
   end

endmodule

// File: rtl/puf_response_collector.sv
// Arbiter-PUF response collector: races the chain once per bit and shifts
// the response in MSB-first. Define PUF_MAJORITY_VOTE_EN for 3-race majority voting.
module puf_response_collector
   import puf_ctrl_pkg::*;
#(
   parameter int CHAL_W        = DEF_CHAL_W,
   parameter int RESP_BITS     = DEF_RESP_BITS,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CHAL_W-1:0]    seed,
   output logic [CHAL_W-1:0]    chal,
   output logic                 launch,
   input  logic                 resp_in,
   output logic [RESP_BITS-1:0] resp_word,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 busy
);

   localparam int BIT_W = $clog2(RESP_BITS + 1);

   state_t           state, state_nxt;
   logic [7:0]       settle_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic             cnt_done;
   logic             accept;
   logic             cap_final;
   logic             cap_bit;

   assign cnt_done = (settle_cnt == 8'(SETTLE_CYCLES - 1));
   assign accept   = (state == IDLE) && start;

`ifdef PUF_MAJORITY_VOTE_EN
   logic [1:0] vote_cnt;
   logic [1:0] ones_cnt;

   // Third race of a challenge: majority of two stored votes plus the live bit
   assign cap_final = (state == CAPTURE) && (vote_cnt == 2'd2);
   assign cap_bit   = ones_cnt[1] | (ones_cnt[0] & resp_in);

   always_ff @(posedge clk) begin
      if (rst || accept || cap_final) begin
         vote_cnt <= '0;
         ones_cnt <= '0;
      end else if (state == CAPTURE) begin
         vote_cnt <= vote_cnt + 2'd1;
         ones_cnt <= ones_cnt + {1'b0, resp_in};
      end
   end
`else
   assign cap_final = (state == CAPTURE);
   assign cap_bit   = resp_in;
`endif

   puf_lfsr #(.CHAL_W(CHAL_W)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .seed (seed),
      .step (cap_final),
      .q    (chal)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = SETTLE;
         SETTLE:  if (cnt_done) state_nxt = CAPTURE;
         CAPTURE: state_nxt = RECOVER;
         RECOVER: if (cnt_done)
                     state_nxt = (bit_cnt == BIT_W'(RESP_BITS)) ? DONE : LAUNCH;
         DONE:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      launch     = 1'b0;
      busy       = 1'b1;
      resp_valid = 1'b0;
      case (state)
         IDLE:           busy = 1'b0;
         LAUNCH, SETTLE: launch = 1'b1;
         DONE:           resp_valid = 1'b1;
         default:        ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
         bit_cnt    <= '0;
         resp_word  <= '0;
      end else begin
         settle_cnt <= ((state == SETTLE || state == RECOVER) && !cnt_done)
                       ? settle_cnt + 8'd1 : '0;
         if (accept) begin
            bit_cnt   <= '0;
            resp_word <= '0;
         end else if (cap_final) begin
            bit_cnt   <= bit_cnt + BIT_W'(1);
            resp_word <= {resp_word[RESP_BITS-2:0], cap_bit};
         end
      end
   end

endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 The block SHALL have parameter CHAL_W, default 45, giving the challenge width and matching the 45-stage arbiter chain.
REQ-002 The block SHALL have parameter RESP_BITS, default 32, giving the number of response bits per word.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 8, giving the race settle/recovery time in clk cycles, valid range 1..255.
REQ-004 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port start, input, 1: begins one response-word collection when the block is idle.
REQ-007 Port seed, input, CHAL_W: initial challenge, sampled when start is accepted.
REQ-008 Port chal, output, CHAL_W: challenge driven to the arbiter chain.
REQ-009 Port launch, output, 1: race signal driven to both X and Y of the arbiter.
REQ-010 Port resp_in, input, 1: arbiter flip-flop output.
REQ-011 Port resp_word, output, RESP_BITS: collected response.
REQ-012 Port resp_valid, output, 1: resp_word is valid.
REQ-013 Port resp_ready, input, 1: consumer accepts resp_word.
REQ-014 Port busy, output, 1: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LAUNCH, SETTLE, CAPTURE, RECOVER and DONE.
REQ-016 IDLE->LAUNCH: start=1 loads chal from seed; a zero seed SHALL be replaced by 1; the bit counter and resp_word SHALL be cleared.
REQ-017 LAUNCH lasts 1 cycle; launch SHALL rise on entry and remain high through SETTLE.
REQ-018 SETTLE lasts exactly SETTLE_CYCLES cycles, then goes to CAPTURE.
REQ-019 CAPTURE lasts 1 cycle:
- samples resp_in;
- shifts it in MSB-first: resp_word <= {resp_word[RESP_BITS-2:0], bit};
- drops launch low;
- advances chal one LFSR step (Fibonacci, taps 45,44,42,41, new bit into chal[0]).
REQ-020 RECOVER lasts SETTLE_CYCLES cycles with launch low, then goes to LAUNCH; after the RESP_BITS-th capture it goes to DONE.
REQ-021 Per-bit period SHALL be 2*SETTLE_CYCLES+2 cycles. resp_valid SHALL rise exactly RESP_BITS*(2*SETTLE_CYCLES+2) cycles after the start-accept edge.
REQ-022 In DONE, resp_valid=1 and resp_word/chal SHALL be stable. On resp_valid&&resp_ready the FSM SHALL go to IDLE and resp_valid SHALL drop next cycle.
REQ-023 start outside IDLE SHALL be ignored, including in the handshake cycle; a start in IDLE one cycle after the handshake SHALL be accepted.
REQ-024 chal SHALL only change at start-accept and in CAPTURE, never while launch is high.

Reset
REQ-025 rst=1 SHALL force, at the next edge and regardless of state (including mid-race):
- state=IDLE;
- launch=0, resp_valid=0, busy=0;
- resp_word=0, chal=0, bit/settle counters=0.
REQ-026 The first start after rst deassertion SHALL be accepted normally.

Configuration
REQ-027 With PUF_MAJORITY_VOTE_EN defined, each challenge SHALL be raced 3 times (LAUNCH/SETTLE/CAPTURE/RECOVER each time) and the majority bit shifted in. The LFSR SHALL advance only after the third capture. Word latency SHALL become 3*RESP_BITS*(2*SETTLE_CYCLES+2).
REQ-028 Without PUF_MAJORITY_VOTE_EN, each bit SHALL come from a single race, and no vote counter logic SHALL be present.

Structure
REQ-029 The shared package puf_ctrl_pkg SHALL hold the FSM state enum, the LFSR tap constant and the default CHAL_W/RESP_BITS/SETTLE_CYCLES values.
REQ-030 The LFSR SHALL be the sub-module puf_lfsr, with ports clk, rst, load, seed, step, and q.

Verification
REQ-031 CHAL_W=45, RESP_BITS=8, SETTLE_CYCLES=4, resp_in tied 1, start with seed=1 -> resp_valid rises 80 cycles after accept, resp_word=8'hFF, busy=1 throughout.
REQ-032 Same setup, resp_in driven by a model returning chal[0] sampled at launch -> resp_word equals the first 8 LFSR bits[0] from seed 1, MSB first. launch SHALL show 8 high pulses, each 5 cycles wide.
REQ-033 seed=0 -> first chal=1. resp_ready held 0 for 20 cycles after valid -> resp_valid and resp_word held stable; start pulses in that window ignored.
REQ-034 rst asserted during the 3rd SETTLE -> next cycle: launch=0, busy=0, resp_word=0. A new start then gives a full correct word.
REQ-035 With PUF_MAJORITY_VOTE_EN, resp_in returns pattern 1,0,1 per challenge -> each bit=1, word=8'hFF, latency 240 cycles.
